// File: rtl/padding_ctrl.sv
// Frame sequencer for the row padding stage: walks one padded frame row by row,
// fetches interior rows from the row buffer and hands each padded row downstream.
module padding_ctrl #(
   parameter int unsigned ROWS = 416,
   parameter int unsigned CW   = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic          rd_en,
   output logic [CW-1:0] rd_addr,
   input  logic          rd_valid,
   output logic          pad_en,
   output logic [CW-1:0] pad_count,
   output logic          row_valid,
   input  logic          row_ready,
   output logic [CW-1:0] row_idx
);

   localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_RD,
      S_OUT,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          is_border;

   // State and row counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   assign is_border = (count_q == '0) || (count_q == LAST_ROW);

   // Next state and strobes; pad_en follows rd_valid within the WAIT_RD cycle,
   // and abort must mask every strobe in the cycle it is seen.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      busy      = (state_q != S_IDLE);
      done      = 1'b0;
      rd_en     = 1'b0;
      pad_en    = 1'b0;
      row_valid = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               count_d = '0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (is_border) begin
               pad_en  = 1'b1;
               state_d = S_OUT;
            end else begin
               rd_en   = 1'b1;
               state_d = S_WAIT_RD;
            end
         end
         S_WAIT_RD: begin
            pad_en = rd_valid;
            if (rd_valid) begin
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            row_valid = 1'b1;
            if (row_ready) begin
               if (count_q == LAST_ROW) begin
                  state_d = S_DONE;
               end else begin
                  count_d = count_q + CW'(1);
                  state_d = S_ISSUE;
               end
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (abort && (state_q != S_IDLE)) begin
         state_d   = S_IDLE;
         count_d   = '0;
         done      = 1'b0;
         rd_en     = 1'b0;
         pad_en    = 1'b0;
         row_valid = 1'b0;
      end
   end

   // Source row is one behind the padded row; zero whenever no read is issued
   assign rd_addr   = rd_en ? (count_q - CW'(1)) : '0;
   assign pad_count = count_q;
   assign row_idx   = count_q;

endmodule

// File: tb/tb_padding_ctrl.sv
// Scoreboard bench for padding_ctrl: stimulus queues expected rows, reads and
// snapshots; a negedge monitor pops and compares as the DUT presents them.
module tb_padding_ctrl;

   localparam int unsigned ROWS = 416;
   localparam int unsigned CW   = 9;

   logic          clk, rst, start, abort, busy, done, rd_en, rd_valid;
   logic          pad_en, row_valid, row_ready;
   logic [CW-1:0] rd_addr, pad_count, row_idx;

   typedef struct {
      int tag;
      bit busy, done, rd_en, pad_en, row_valid, chk_addr;
      int pad_count;
   } snap_t;

   snap_t snap_q[$];
   int    exp_row_q[$];
   int    exp_rd_q[$];
   int    exp_done_q[$];

   int    n_cmp = 0;
   int    n_fail = 0;

   int    lat_fixed  = 1;
   bit    lat_rand   = 0;
   bit    stall_mode = 0;
   bit    spur_mode  = 0;
   bit    tmo_req    = 0;
   string tmo_name   = "";

   padding_ctrl #(.ROWS(ROWS), .CW(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .pad_en(pad_en),
      .pad_count(pad_count), .row_valid(row_valid), .row_ready(row_ready),
      .row_idx(row_idx)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Row buffer model and downstream sink; drives at posedge+1
   initial begin : responder
      int cnt;
      cnt       = 0;
      rd_valid  = 1'b0;
      row_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (rd_en && !rst) cnt = lat_rand ? int'($urandom_range(8, 1)) : lat_fixed;
         @(posedge clk);
         #1;
         if (rst) begin
            cnt      = 0;
            rd_valid = 1'b0;
         end else if (cnt > 0) begin
            cnt      = cnt - 1;
            rd_valid = (cnt == 0);
         end else begin
            rd_valid = spur_mode && (row_valid || rd_en || !busy);
         end
         row_ready = stall_mode ? ($urandom_range(2, 0) != 0) : 1'b1;
      end
   end

   task automatic chk(input string name, input int act, input int req);
      n_cmp = n_cmp + 1;
      if (act != req) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: all comparisons happen here, on the falling edge
   int    cyc, pad_cnt, rd_cnt, prev_idx;
   bit    prev_busy, prev_pad, prev_rv, prev_rr, busy_chk;
   snap_t s;

   always @(negedge clk) begin
      if (rst) begin
         prev_busy = 0; prev_pad = 0; prev_rv = 0; prev_rr = 0; busy_chk = 0;
         cyc = 0; pad_cnt = 0; rd_cnt = 0; prev_idx = 0;
      end else begin
         if (busy && !prev_busy) begin
            cyc = 1; pad_cnt = 0; rd_cnt = 0;
         end else if (busy) begin
            cyc = cyc + 1;
         end
         if (busy_chk) begin
            chk("busy_after_done", int'(busy), 0);
            busy_chk = 0;
         end
         if (pad_en) begin
            pad_cnt = pad_cnt + 1;
            chk("pad_en_in_frame", int'(busy), 1);
            chk("pad_en_not_in_out", int'(row_valid), 0);
         end
         if (prev_pad && !abort) chk("row_valid_after_pad", int'(row_valid), 1);
         if (prev_rv && !prev_rr && !abort) begin
            chk("stall_row_valid", int'(row_valid), 1);
            chk("stall_row_idx", int'(row_idx), prev_idx);
         end
         if (rd_en) begin
            rd_cnt = rd_cnt + 1;
            if (exp_rd_q.size() == 0) chk("rd_extra", int'(rd_addr), -1);
            else chk("rd_addr", int'(rd_addr), exp_rd_q.pop_front());
         end
         if (row_valid && row_ready) begin
            if (exp_row_q.size() == 0) chk("row_extra", int'(row_idx), -1);
            else chk("row_idx", int'(row_idx), exp_row_q.pop_front());
         end
         if (done) begin
            if (exp_done_q.size() == 0) begin
               chk("done_unexpected", 1, 0);
            end else begin
               int d;
               d = exp_done_q.pop_front();
               if (d != 0) chk("done_cycle", cyc, d);
               chk("pad_en_per_frame", pad_cnt, ROWS);
               chk("rd_en_per_frame", rd_cnt, ROWS - 2);
               chk("rows_left_at_done", exp_row_q.size(), 0);
            end
            busy_chk = 1;
         end
         prev_busy = busy;
         prev_pad  = pad_en;
         prev_rv   = row_valid;
         prev_rr   = row_ready;
         prev_idx  = int'(row_idx);
      end
      while (snap_q.size() > 0) begin
         s = snap_q.pop_front();
         chk($sformatf("snap%0d_busy", s.tag), int'(busy), int'(s.busy));
         chk($sformatf("snap%0d_done", s.tag), int'(done), int'(s.done));
         chk($sformatf("snap%0d_rd_en", s.tag), int'(rd_en), int'(s.rd_en));
         chk($sformatf("snap%0d_pad_en", s.tag), int'(pad_en), int'(s.pad_en));
         chk($sformatf("snap%0d_row_valid", s.tag), int'(row_valid), int'(s.row_valid));
         chk($sformatf("snap%0d_pad_count", s.tag), int'(pad_count), s.pad_count);
         chk($sformatf("snap%0d_row_idx", s.tag), int'(row_idx), s.pad_count);
         if (s.chk_addr) chk($sformatf("snap%0d_rd_addr", s.tag), int'(rd_addr), 0);
      end
      if (tmo_req) begin
         n_cmp  = n_cmp + 1;
         n_fail = n_fail + 1;
         $display("FAIL timeout_%s: bound expired, got no DUT event, required one", tmo_name);
      end
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic snap(input int tag, input bit b, input bit d, input bit r, input bit p,
                       input bit v, input int pc, input bit ca);
      snap_t n;
      n.tag = tag; n.busy = b; n.done = d; n.rd_en = r; n.pad_en = p;
      n.row_valid = v; n.pad_count = pc; n.chk_addr = ca;
      snap_q.push_back(n);
   endtask

   task automatic timeout(input string nm);
      tmo_name = nm;
      tmo_req  = 1;
      tick;
      tmo_req  = 0;
   endtask

   task automatic flush_exp;
      exp_row_q.delete();
      exp_rd_q.delete();
      exp_done_q.delete();
   endtask

   task automatic start_frame(input int done_cyc);
      for (int r = 0; r < int'(ROWS); r++) exp_row_q.push_back(r);
      for (int r = 0; r < int'(ROWS) - 2; r++) exp_rd_q.push_back(r);
      exp_done_q.push_back(done_cyc);
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string nm, input bit poke_start);
      bit ok;
      ok = 0;
      for (int i = 0; i < 20000; i++) begin
         if (!busy) begin
            ok = 1;
            break;
         end
         if (poke_start && (i % 97 == 50)) begin
            start = 1'b1;
            tick;
            start = 1'b0;
         end else begin
            tick;
         end
      end
      if (!ok) timeout(nm);
   endtask

   task automatic wait_row(input string nm, input int row, input bit in_out);
      bit ok;
      ok = 0;
      for (int i = 0; i < 20000; i++) begin
         if (busy && int'(pad_count) == row &&
             (in_out ? row_valid : (!rd_en && !row_valid))) begin
            ok = 1;
            break;
         end
         tick;
      end
      if (!ok) timeout(nm);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      snap(0, 0, 0, 0, 0, 0, 0, 1);
      tick;

      // Ideal frame: L=1, no stalls
      start_frame(1247);
      wait_idle("frame_ideal", 0);
      snap(1, 0, 0, 0, 0, 0, ROWS - 1, 0);
      tick;

      // Random latency and backpressure
      lat_rand = 1; stall_mode = 1;
      start_frame(0);
      wait_idle("frame_stall", 0);
      lat_rand = 0; stall_mode = 0;
      tick;

      // Spurious rd_valid in IDLE/ISSUE/OUT and start pulses mid-frame
      spur_mode = 1;
      repeat (4) tick;
      start_frame(1247);
      wait_idle("frame_spur", 1);
      spur_mode = 0;
      tick;

      // Abort in WAIT_RD of row 100; the late rd_valid lands in IDLE
      lat_fixed = 8;
      start_frame(0);
      wait_row("abort_wait", 100, 0);
      abort = 1'b1;
      flush_exp();
      snap(2, 1, 0, 0, 0, 0, 100, 0);
      tick;
      abort = 1'b0;
      snap(3, 0, 0, 0, 0, 0, 0, 0);
      repeat (12) tick;
      lat_fixed = 1;

      // abort with start in IDLE stays idle
      start = 1'b1; abort = 1'b1;
      tick;
      start = 1'b0; abort = 1'b0;
      snap(4, 0, 0, 0, 0, 0, 0, 0);
      tick;

      start_frame(1247);
      wait_idle("frame_after_abort", 0);
      tick;

      // Async reset between edges while in OUT of row 200
      lat_rand = 1; stall_mode = 1;
      start_frame(0);
      wait_row("reset_wait", 200, 1);
      rst = 1'b1;
      flush_exp();
      snap(5, 0, 0, 0, 0, 0, 0, 1);
      tick;
      tick;
      rst = 1'b0;
      lat_rand = 0; stall_mode = 0;
      snap(6, 0, 0, 0, 0, 0, 0, 1);
      tick;
      start_frame(1247);
      wait_idle("frame_after_reset", 0);

      repeat (5) tick;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/padding_ctrl.md
# padding_ctrl

Frame sequencer for the row padding stage. It steps through one padded frame row by row and fetches each interior source row from the image row buffer. It drives the padding stage's `en`/`count` inputs and presents each padded row to the downstream convolution line buffer with a valid/ready handshake. It sits between the row buffer read port, the padding stage and the first conv layer.

## Interface
- `ROWS`, default 416: padded rows per frame. Count runs 0..ROWS-1. Rows 0 and ROWS-1 are border (zero) rows; all others are interior.
- `CW`, default 9: width of count/address fields. Requires ROWS <= 2^CW.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a frame; accepted only in IDLE.
- `abort`  in  1  synchronous frame cancel; return to IDLE next cycle.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last row handshake.
- `rd_en`  out  1  one-cycle read request to the row buffer.
- `rd_addr`  out  CW  source row index = `pad_count`-1; valid only while `rd_en`=1.
- `rd_valid`  in  1  row buffer data present at the padding inputs this cycle; arrives after variable latency ≥1.
- `pad_en`  out  1  padding stage enable; the padded row registers at the end of this cycle.
- `pad_count`  out  CW  current padded row index, wired to the padding stage `count`.
- `row_valid`  out  1  padded row available downstream.
- `row_ready`  in  1  downstream accepts the row.
- `row_idx`  out  CW  index of the row under `row_valid`; equals `pad_count`.

## Operation
- States: IDLE, ISSUE, WAIT_RD, OUT, DONE.
- IDLE: all strobes low. `start`=1 sets `pad_count`<=0 and moves to ISSUE.
- ISSUE, border row (`pad_count`==0 or ROWS-1): `pad_en`=1 for this cycle, no read issued, go to OUT.
- ISSUE, interior row: `rd_en`=1 with `rd_addr`=`pad_count`-1 for exactly one cycle, go to WAIT_RD.
- WAIT_RD: `pad_en` = `rd_valid`, driven combinationally from state. On `rd_valid`=1, go to OUT.
- OUT: `row_valid`=1 and held with stable `row_idx` until `row_ready`=1.
  - On handshake with `pad_count`==ROWS-1: go to DONE.
  - On any other handshake: `pad_count`++ and go to ISSUE.
- DONE: `done`=1 for one cycle, then IDLE. `pad_count` keeps ROWS-1 until the next start.
- `rd_en` and `pad_en` are each at most one cycle per row. There is exactly one `pad_en` per row and exactly ROWS `pad_en` pulses per frame.
- Ignored inputs:
  - `start` outside IDLE.
  - `rd_valid` outside WAIT_RD (no `pad_en`, no state change).
  - `row_ready` outside OUT.
- `abort` has priority over every transition:
  - From any non-IDLE state, go to IDLE next cycle with `pad_count`<=0.
  - No `done` pulse.
  - `pad_en`, `rd_en` and `row_valid` are forced low in the abort cycle.
  - A late `rd_valid` for the cancelled read is ignored per the rule above.
- `abort` together with `start` in IDLE: stay in IDLE.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0, `pad_en`=0, `pad_count`=0, `row_valid`=0, `row_idx`=0.
- Reset mid-frame: immediate return to IDLE. No `done` pulse. Outstanding reads are forgotten.
- `busy` rises the cycle after `start` and falls the cycle after DONE.
- Border row: ISSUE (1 cycle) then OUT. `row_valid` is high the cycle after `pad_en`, matching the padding output register latency.
- Interior row: ISSUE (1) + WAIT_RD (read latency L≥1) + OUT. `row_valid` is high the cycle after the `rd_valid`/`pad_en` cycle.
- Minimum frame with `row_ready` tied high and L=1:
  - 2 border rows at 2 cycles each.
  - (ROWS-2) interior rows at 3 cycles each.
  - Plus 1 DONE cycle.
  - ROWS=416 gives 1247 cycles from the first ISSUE to `done`.
- Backpressure: while `row_ready`=0 in OUT, no new `pad_en` or `rd_en` is issued, so the padding output holds.
- `rd_addr` range: 0..ROWS-3. It never underflows or exceeds the source height.

## Test plan
- Full frame: ROWS=416, L=1, `row_ready`=1. Expect:
  - 416 `pad_en` pulses and 414 `rd_en` pulses.
  - `rd_addr` sequence 0..413.
  - `row_idx` sequence 0..415.
  - `done` exactly at cycle 1247 after the first ISSUE.
  - `busy` low one cycle later.
- Border rows: check rows 0 and 415 produce `pad_en` with no `rd_en`, and `row_valid` exactly 1 cycle after `pad_en`.
- Variable latency and backpressure:
  - Random L of 1–8 cycles and random `row_ready` stalls.
  - `row_valid`/`row_idx` stay stable until the handshake.
  - No `pad_en` occurs during a stall.
  - Row order stays 0..415.
- Spurious inputs: `start` pulses mid-frame and `rd_valid` pulses in ISSUE/OUT/IDLE. Expect no effect on the sequence and no extra `pad_en`.
- Abort: `abort` asserted in WAIT_RD of row 100. Expect:
  - IDLE next cycle with `pad_count`=0 and no `done`.
  - A late `rd_valid` produces no `pad_en`.
  - A following `start` runs a clean full frame.
- Async reset: assert `rst` between clock edges in OUT of row 200. Expect all outputs at reset values immediately, and a new frame to work after release.
